// File: rtl/mem_interface_if.sv
// Bus bundle between the datapath/RAM side (master) and mem_interface (slave).
// state_dbg mirrors the controller FSM state for observation.
interface mem_interface_if;
  logic [31:0] BusMuxOut;
  logic        MARin;
  logic        MDRin;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] Mdatain;
  logic [8:0]  address;
  logic [31:0] ram_wdata;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] MDRout_data;
  logic        busy;
  logic        done;
  logic        verify_err;
  logic [1:0]  state_dbg;

  modport master (
    output BusMuxOut, MARin, MDRin, rd_req, wr_req, Mdatain,
    input  address, ram_wdata, ram_read, ram_write, MDRout_data,
    input  busy, done, verify_err, state_dbg
  );

  modport slave (
    input  BusMuxOut, MARin, MDRin, rd_req, wr_req, Mdatain,
    output address, ram_wdata, ram_read, ram_write, MDRout_data,
    output busy, done, verify_err, state_dbg
  );
endinterface

// File: rtl/mem_interface.sv
// MAR/MDR memory interface with counted read/write strobes and a done pulse.
// Define MEM_IF_WRITE_VERIFY_EN to add read-back verification after each write.
module mem_interface #(
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input logic            clock,
  input logic            clear,
  mem_interface_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_VFY  = 2'd3;

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic        done_q, done_d;
`ifdef MEM_IF_WRITE_VERIFY_EN
  logic        verr_q, verr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    done_d  = 1'b0;
`ifdef MEM_IF_WRITE_VERIFY_EN
    verr_d  = verr_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Register loads land on the same edge as a request, so the
        // transaction sees the freshly loaded MAR/MDR.
        if (bus.MARin) mar_d = bus.BusMuxOut[8:0];
        if (bus.MDRin) mdr_d = bus.BusMuxOut;
        if (bus.wr_req) begin
          state_d = S_WR;
          cnt_d   = WR_LOAD;
        end else if (bus.rd_req) begin
          state_d = S_RD;
          cnt_d   = RD_LOAD;
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          mdr_d   = bus.Mdatain;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR: begin
        if (cnt_q == 4'd0) begin
`ifdef MEM_IF_WRITE_VERIFY_EN
          state_d = S_VFY;
          cnt_d   = RD_LOAD;
`else
          state_d = S_IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef MEM_IF_WRITE_VERIFY_EN
      S_VFY: begin
        if (cnt_q == 4'd0) begin
          if (bus.Mdatain != mdr_q) verr_d = 1'b1;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      mar_q   <= 9'd0;
      mdr_q   <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      done_q  <= done_d;
    end
  end

`ifdef MEM_IF_WRITE_VERIFY_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear) verr_q <= 1'b0;
    else       verr_q <= verr_d;
  end
  assign bus.verify_err = verr_q;
`else
  assign bus.verify_err = 1'b0;
`endif

  // Strobes decode straight from the state flop so reset clears them at once.
  assign bus.address     = mar_q;
  assign bus.ram_wdata   = mdr_q;
  assign bus.MDRout_data = mdr_q;
  assign bus.ram_read    = (state_q == S_RD) || (state_q == S_VFY);
  assign bus.ram_write   = (state_q == S_WR);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: directed vector table, corner sequences, and
// randomized transactions against a transaction-level memory model.
module tb_mem_interface;

  localparam int RD_WAIT = 1;
  localparam int WR_WAIT = 2;
`ifdef MEM_IF_WRITE_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif
  localparam int RD_LAT = RD_WAIT;
  localparam int WR_LAT = WR_WAIT + (VERIFY_ON ? RD_WAIT : 0);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic clear = 1'b1;
  logic init_ram = 1'b1;
  logic corrupt = 1'b0;
  always #5 clock = ~clock;

  mem_interface_if bus();

  mem_interface #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  // ---------------- RAM environment ----------------
  logic [31:0] ram [512];

  function automatic logic [31:0] init_val(input int i);
    if (i == 32'h55) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0001;
  endfunction

  always @(posedge clock) begin
    if (init_ram) begin
      for (int i = 0; i < 512; i++) ram[i] <= init_val(i);
    end else if (bus.ram_write) begin
      ram[bus.address] <= bus.ram_wdata;
    end
  end

  assign bus.Mdatain = ram[bus.address] ^ {31'd0, corrupt};

  // ---------------- reference model ----------------
  logic [31:0] m_mem [512];
  logic [31:0] m_mdr;

  // A write stores MDR at the address; a read copies the word into MDR.
  // A combined request counts as a write.
  task automatic model_txn(input logic [1:0] op, input logic [8:0] addr,
                           input bit load, input logic [31:0] wdata);
    if (load) m_mdr = wdata;
    if (op[1])      m_mem[addr] = m_mdr;
    else if (op[0]) m_mdr = m_mem[addr];
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_txn(input string nm, input logic [1:0] op, input logic [8:0] addr,
                         input bit load, input logic [31:0] wdata,
                         input logic [31:0] exp_mdr, input bit poke);
    logic [31:0] bm;
    int lat, rc, wc, ovl, abad, wbad, exp_rc, exp_wc, exp_lat;
    bit seen, b, busy_at_done;
    bm = $urandom();
    bm[8:0] = addr;
    exp_lat = op[1] ? WR_LAT : RD_LAT;
    exp_wc  = op[1] ? WR_WAIT : 0;
    exp_rc  = op[1] ? (VERIFY_ON ? RD_WAIT : 0) : RD_WAIT;
    if (load) begin
      @(negedge clock);
      bus.BusMuxOut = wdata;
      bus.MDRin = 1'b1;
    end
    @(negedge clock);
    bus.MDRin = 1'b0;
    bus.BusMuxOut = bm;
    bus.MARin = 1'b1;
    bus.rd_req = op[0];
    bus.wr_req = op[1];
    lat = -1; rc = 0; wc = 0; ovl = 0; abad = 0; wbad = 0; busy_at_done = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      seen = bus.done;
      b = bus.busy;
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
      if (i == 0 && poke) begin
        bus.MARin = 1'b1; bus.MDRin = 1'b1; bus.BusMuxOut = 32'h0000_00AA;
      end else begin
        bus.MARin = 1'b0; bus.MDRin = 1'b0;
      end
      if (seen) begin
        lat = i;
        busy_at_done = b;
        break;
      end
      rc += int'(bus.ram_read);
      wc += int'(bus.ram_write);
      if (bus.ram_read && bus.ram_write) ovl++;
      if (bus.address !== addr) abad++;
      if (bus.ram_write && bus.ram_wdata !== exp_mdr) wbad++;
    end
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " ram_read cycles"}, rc, exp_rc);
    check({nm, " ram_write cycles"}, wc, exp_wc);
    check({nm, " strobe overlap"}, ovl, 0);
    check({nm, " address unstable"}, abad, 0);
    check({nm, " wdata unstable"}, wbad, 0);
    check({nm, " busy in done cycle"}, busy_at_done, 0);
    @(negedge clock);
    check({nm, " done single pulse"}, bus.done, 0);
    check({nm, " MAR held"}, bus.address, addr);
    exp_q.push_back(exp_mdr);
    check({nm, " MDR"}, bus.MDRout_data, exp_q.pop_front());
    if (op[1]) check({nm, " RAM word"}, ram[addr], m_mem[addr]);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [8:0]  addr;
    bit          load;
    logic [31:0] wdata;
    logic [31:0] exp_mdr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'b01, 9'h055, 1'b0, 32'h0,         32'hDEADBEEF};
    vecs[1] = '{2'b10, 9'h1FF, 1'b1, 32'h12345678, 32'h12345678};
    vecs[2] = '{2'b01, 9'h1FF, 1'b0, 32'h0,         32'h12345678};
    vecs[3] = '{2'b11, 9'h010, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[4] = '{2'b01, 9'h002, 1'b0, 32'h0,         32'h10020002};
    vecs[5] = '{2'b10, 9'h003, 1'b0, 32'h0,         32'h10020002};
    vecs[6] = '{2'b01, 9'h010, 1'b0, 32'h0,         32'hA5A5A5A5};
    vecs[7] = '{2'b01, 9'h003, 1'b0, 32'h0,         32'h10020002};

    bus.BusMuxOut = 32'd0; bus.MARin = 1'b0; bus.MDRin = 1'b0;
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    for (int i = 0; i < 512; i++) m_mem[i] = init_val(i);
    m_mdr = 32'd0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset address", bus.address, 0);
    check("reset MDR", bus.MDRout_data, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset ram_read", bus.ram_read, 0);
    check("reset ram_write", bus.ram_write, 0);
    check("reset verify_err", bus.verify_err, 0);
    clear = 1'b0;
    init_ram = 1'b0;

    for (int v = 0; v < 8; v++) begin
      model_txn(vecs[v].op, vecs[v].addr, vecs[v].load, vecs[v].wdata);
      run_txn($sformatf("vec%0d", v), vecs[v].op, vecs[v].addr, vecs[v].load,
              vecs[v].wdata, vecs[v].exp_mdr, 1'b0);
    end

    // Loads while busy are ignored; the next idle load takes effect
    model_txn(2'b01, 9'h1FF, 1'b0, 32'h0);
    run_txn("busy poke", 2'b01, 9'h1FF, 1'b0, 32'h0, 32'h12345678, 1'b1);
    bus.MARin = 1'b1; bus.BusMuxOut = 32'h0000_00AA;
    @(negedge clock);
    bus.MARin = 1'b0;
    check("idle MAR load", bus.address, 9'h0AA);

    // Write with corrupted read-back
    corrupt = 1'b1;
    model_txn(2'b10, 9'h020, 1'b1, 32'hCAFEF00D);
    run_txn("verify write", 2'b10, 9'h020, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    corrupt = 1'b0;
    check("verify_err set", bus.verify_err, VERIFY_ON);
    model_txn(2'b01, 9'h020, 1'b0, 32'h0);
    run_txn("verify read", 2'b01, 9'h020, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
    check("verify_err sticky", bus.verify_err, VERIFY_ON);

    // Clear in the middle of a read
    @(negedge clock);
    bus.MARin = 1'b1; bus.BusMuxOut = 32'h0000_0055; bus.rd_req = 1'b1;
    @(negedge clock);
    bus.MARin = 1'b0; bus.rd_req = 1'b0;
    check("mid-RD ram_read before clear", bus.ram_read, 1);
    #2 clear = 1'b1;
    #1;
    check("clear ram_read", bus.ram_read, 0);
    check("clear busy", bus.busy, 0);
    check("clear MAR", bus.address, 0);
    check("clear MDR", bus.MDRout_data, 0);
    check("clear done", bus.done, 0);
    check("clear verify_err", bus.verify_err, 0);
    @(negedge clock);
    clear = 1'b0;
    m_mdr = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("no done after abort", bus.done, 0);
    end

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  op;
      logic [8:0]  addr;
      bit          load, poke;
      logic [31:0] wdata;
      op    = 2'($urandom_range(1, 3));
      addr  = 9'($urandom_range(0, 511));
      load  = 1'($urandom_range(0, 1));
      poke  = 1'($urandom_range(0, 1));
      wdata = $urandom();
      repeat ($urandom_range(0, 2)) @(negedge clock);
      model_txn(op, addr, load, wdata);
      run_txn($sformatf("rand%0d", t), op, addr, load, wdata, m_mdr, poke);
    end
    check("final verify_err", bus.verify_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
